// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB holding register and load-wait FSM feeding the register bank write port.
module writeback_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_RegWrite,
    input  logic        mem_MemtoReg,
    input  logic [4:0]  mem_WriteRegister,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_rvalid,
    output logic [4:0]  rd_wb,
    output logic        w_en_wb,
    output logic [31:0] d_in_wb,
    output logic        load_timeout,
    output logic [31:0] retire_cnt
);
    typedef enum logic {IDLE, WAIT_LOAD} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_wait_cnt;
    logic [4:0]  r_hold_rd, r_rd;
    logic        r_hold_rw, r_wen, r_timeout;
    logic [31:0] r_d, r_retire;
    logic        w_accept, w_direct, w_load_done, w_timeout;
    assign mem_ready    = (r_state == IDLE);
    assign w_accept     = mem_valid && mem_ready;
    assign w_direct     = w_accept && (!mem_MemtoReg || dmem_rvalid);
    assign w_load_done  = (r_state == WAIT_LOAD) && dmem_rvalid;
    // data arriving on the edge the counter would hit 15 takes priority over the timeout
    assign w_timeout    = (r_state == WAIT_LOAD) && !dmem_rvalid && (r_wait_cnt == 4'd14);
    assign rd_wb        = r_rd;
    assign w_en_wb      = r_wen;
    assign d_in_wb      = r_d;
    assign load_timeout = r_timeout;
    assign retire_cnt   = r_retire;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_accept && !w_direct) w_next = WAIT_LOAD;
        else if (w_load_done || w_timeout) w_next = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd       <= 5'd0;
            r_d        <= 32'd0;
            r_wen      <= 1'b0;
            r_retire   <= 32'd0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= 4'd0;
            r_hold_rd  <= 5'd0;
            r_hold_rw  <= 1'b0;
        end else begin
            r_wen      <= 1'b0;
            r_wait_cnt <= (r_state == WAIT_LOAD) ? r_wait_cnt + 4'd1 : 4'd0;
            if (w_direct) begin
                r_rd     <= mem_WriteRegister;
                r_d      <= mem_MemtoReg ? dmem_rdata : mem_alu_result;
                r_wen    <= mem_RegWrite && (|mem_WriteRegister);
                r_retire <= r_retire + 32'd1;
            end else if (w_load_done) begin
                r_rd     <= r_hold_rd;
                r_d      <= dmem_rdata;
                r_wen    <= r_hold_rw && (|r_hold_rd);
                r_retire <= r_retire + 32'd1;
            end
            if (w_accept) begin
                r_hold_rd <= mem_WriteRegister;
                r_hold_rw <= mem_RegWrite;
            end
            if (w_timeout) r_timeout <= 1'b1;
        end
    end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 clk  input  1  rising-edge clock shared with the decode stage and register bank.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 mem_valid  input  1  MEM stage presents an instruction this cycle.
REQ-005 mem_ready  output  1  writeback_stage can accept an instruction this cycle.
REQ-006 mem_RegWrite  input  1  instruction writes the register bank.
REQ-007 mem_MemtoReg  input  1  result comes from data memory (load), not the ALU.
REQ-008 mem_WriteRegister  input  5  destination register (rt/rd already selected by RegDst).
REQ-009 mem_alu_result  input  32  ALU result.
REQ-010 dmem_rdata  input  32  data-memory read data, valid only when dmem_rvalid=1.
REQ-011 dmem_rvalid  input  1  load data returned this cycle.
REQ-012 rd_wb  output  5  register-bank write address to the decode stage.
REQ-013 w_en_wb  output  1  register-bank write enable to the decode stage, one-cycle pulse.
REQ-014 d_in_wb  output  32  register-bank write data to the decode stage.
REQ-015 load_timeout  output  1  sticky error: a load got no data within the timeout.
REQ-016 retire_cnt  output  32  count of completed instructions.

Function
REQ-017 The block SHALL implement a two-state FSM: IDLE, WAIT_LOAD.
REQ-018 An instruction is accepted on a rising edge where mem_valid=1 and mem_ready=1. Its fields are registered into the MEM/WB holding register.
REQ-019 mem_ready SHALL be 1 in IDLE and 0 in WAIT_LOAD. It is a combinational function of state only.
REQ-020 Non-load accept (MemtoReg=0) in IDLE: on the next cycle, rd_wb=WriteRegister, d_in_wb=alu_result, and w_en_wb=RegWrite AND (WriteRegister!=0). The FSM stays in IDLE. Back-to-back accepts give one write per cycle.
REQ-021 Load accept with dmem_rvalid=1 in the same cycle: on the next cycle, d_in_wb=dmem_rdata and write per REQ-020. The FSM stays in IDLE.
REQ-022 Load accept with dmem_rvalid=0: the FSM enters WAIT_LOAD and the 4-bit wait counter is cleared to 0.
REQ-023 In WAIT_LOAD the wait counter increments each cycle. On the first cycle with dmem_rvalid=1, the block captures dmem_rdata, issues the write on the following cycle, and returns to IDLE.
REQ-024 In WAIT_LOAD, if the counter reaches 15 with dmem_rvalid still 0, the block SHALL set load_timeout=1 (sticky until reset), return to IDLE, issue no write, and not increment retire_cnt.
REQ-025 If dmem_rvalid=1 arrives in the same cycle the counter would reach 15, the data wins: normal completion, no timeout.
REQ-026 dmem_rvalid=1 in IDLE with no load being accepted SHALL be ignored.
REQ-027 Writes to register 0 SHALL never assert w_en_wb. They still retire.
REQ-028 retire_cnt SHALL increment by 1 in the cycle the write slot of each completed instruction is issued, whether or not w_en_wb=1. It wraps from 0xFFFFFFFF to 0.
REQ-029 w_en_wb SHALL be 0 in every cycle without a completing instruction. rd_wb and d_in_wb hold their last values.
REQ-030 Write latency SHALL be exactly 1 cycle after data is available (accept edge for ALU ops; rvalid edge for loads).

Reset
REQ-031 While rst_n=0, the block SHALL hold these values: state=IDLE, mem_ready=1, rd_wb=0, w_en_wb=0, d_in_wb=0, load_timeout=0, retire_cnt=0, wait counter=0.
REQ-032 Reset asserted mid-WAIT_LOAD SHALL abandon the pending load with no write. A dmem_rvalid arriving after reset releases is ignored per REQ-026.

Verification
REQ-033 ALU op: accept RegWrite=1, MemtoReg=0, WriteRegister=5, alu_result=0x12345678 -> next cycle w_en_wb=1, rd_wb=5, d_in_wb=0x12345678, retire_cnt=1.
REQ-034 Load with rvalid 3 cycles late: accept MemtoReg=1, WriteRegister=8; dmem_rvalid=1 with rdata=0xDEADBEEF three cycles later -> mem_ready=0 for 3 cycles, then w_en_wb=1, rd_wb=8, d_in_wb=0xDEADBEEF one cycle after rvalid.
REQ-035 Register zero: accept RegWrite=1, WriteRegister=0, alu_result=0xFFFFFFFF -> w_en_wb stays 0 and retire_cnt increments.
REQ-036 Timeout: accept a load and never assert rvalid -> after 15 wait cycles load_timeout=1, state=IDLE, no w_en_wb pulse, retire_cnt unchanged; a later ALU op still completes.
REQ-037 Back-to-back: four ALU ops on consecutive cycles to registers 1..4 -> four consecutive w_en_wb pulses in order, retire_cnt=4.
REQ-038 Reset mid-wait: accept a load, pull rst_n low for 1 cycle during WAIT_LOAD, then assert rvalid -> no write, all outputs at reset values, mem_ready=1.
